// File: rtl/rn_stage_pkg.sv
// rtl/rn_stage_pkg.sv - shared sizes, tag types and the rename-to-dispatch packet
package rn_stage_pkg;

  localparam int ARCH_REGS  = 32;
  localparam int PRF_SIZE   = 64;
  localparam int ARCH_IDX_W = $clog2(ARCH_REGS);
  localparam int PRF_IDX_W  = $clog2(PRF_SIZE);
  localparam int FL_DEPTH   = PRF_SIZE - ARCH_REGS;
  localparam int FL_IDX_W   = $clog2(FL_DEPTH);
  localparam int FL_CNT_W   = $clog2(FL_DEPTH + 1);

  typedef logic [ARCH_IDX_W-1:0] arch_idx_t;
  typedef logic [PRF_IDX_W-1:0]  prf_idx_t;
  typedef logic [FL_IDX_W-1:0]   fl_idx_t;
  typedef logic [FL_CNT_W-1:0]   fl_cnt_t;

  typedef struct packed {
    logic      valid;
    arch_idx_t rs1;
    arch_idx_t rs2;
    arch_idx_t rd;
    logic      has_dest;
    prf_idx_t  prs1;
    prf_idx_t  prs2;
    prf_idx_t  prd;
    prf_idx_t  old_prd;
  } rn_dp_packet_t;

  function automatic fl_idx_t fl_wrap(input fl_idx_t ptr, input logic [1:0] n);
    int unsigned sum;
    sum = 32'(ptr) + 32'(n);
    return fl_idx_t'(sum % FL_DEPTH);
  endfunction

endpackage

// File: rtl/rn_freelist.sv
// rtl/rn_freelist.sv - circular free list: 2-pop at head, 2-push at tail, rt_head restore on squash
module rn_freelist import rn_stage_pkg::*; (
  input  logic            clock,
  input  logic            reset,
  input  logic [1:0]      alloc_cnt,
  input  logic [1:0]      push_en,
  input  prf_idx_t [1:0]  push_tag,
  input  logic            squash,
  output prf_idx_t [1:0]  pop_tag,
  output fl_cnt_t         free_count
);

  prf_idx_t   mem_q [FL_DEPTH];
  prf_idx_t   mem_d [FL_DEPTH];
  fl_idx_t    head_q, head_d;
  fl_idx_t    tail_q, tail_d;
  fl_idx_t    rt_head_q, rt_head_d;
  fl_cnt_t    count_q, count_d;
  logic [1:0] push_cnt;

  always_comb begin
    mem_d    = mem_q;
    tail_d   = tail_q;
    push_cnt = {1'b0, push_en[0]} + {1'b0, push_en[1]};
    for (int s = 0; s < 2; s++) begin
      if (push_en[s]) begin
        mem_d[tail_d] = push_tag[s];
        tail_d        = fl_wrap(tail_d, 2'd1);
      end
    end
    // every retire consumes exactly one allocation, in allocation order
    rt_head_d = fl_wrap(rt_head_q, push_cnt);
    if (squash) begin
      head_d  = rt_head_d;
      count_d = fl_cnt_t'(FL_DEPTH);
    end else begin
      head_d  = fl_wrap(head_q, alloc_cnt);
      count_d = count_q - fl_cnt_t'(alloc_cnt) + fl_cnt_t'(push_cnt);
    end
  end

  assign pop_tag[0] = mem_q[head_q];
  assign pop_tag[1] = mem_q[fl_wrap(head_q, 2'd1)];
  assign free_count = count_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < FL_DEPTH; i++) mem_q[i] <= prf_idx_t'(ARCH_REGS + i);
      head_q    <= '0;
      tail_q    <= '0;
      rt_head_q <= '0;
      count_q   <= fl_cnt_t'(FL_DEPTH);
    end else begin
      mem_q     <= mem_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      rt_head_q <= rt_head_d;
      count_q   <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) assert (count_q <= fl_cnt_t'(FL_DEPTH));
  end

endmodule

// File: rtl/rn_stage.sv
// rtl/rn_stage.sv - 2-wide rename stage: map table, retirement map, intra-group bypass
// Optional RN_STATS_EN adds saturating rn_stall_cycles / rn_fl_empty_cycles outputs.
module rn_stage import rn_stage_pkg::*; (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [1:0]           id_valid,
  input  arch_idx_t [1:0]      id_rs1,
  input  arch_idx_t [1:0]      id_rs2,
  input  arch_idx_t [1:0]      id_rd,
  input  logic [1:0]           id_has_dest,
  input  logic                 dp_stall,
  input  logic [1:0]           rt_valid,
  input  arch_idx_t [1:0]      rt_rd,
  input  prf_idx_t [1:0]       rt_prd,
  input  prf_idx_t [1:0]       rt_old,
  input  logic                 squash,
  output logic                 rn_stall,
  output rn_dp_packet_t [1:0]  rn_dp_packet
`ifdef RN_STATS_EN
  ,
  output logic [31:0]          rn_stall_cycles,
  output logic [31:0]          rn_fl_empty_cycles
`endif
);

  prf_idx_t            mt_q [ARCH_REGS];
  prf_idx_t            mt_d [ARCH_REGS];
  prf_idx_t            rrat_q [ARCH_REGS];
  prf_idx_t            rrat_d [ARCH_REGS];
  rn_dp_packet_t [1:0] pkt_q, pkt_d;
  logic [1:0]          dest, push_en, need, alloc_cnt;
  logic                shortage, accept;
  prf_idx_t [1:0]      pop_tag, prs1, prs2, prd, old_prd;
  fl_cnt_t             free_count;

  rn_freelist u_freelist (
    .clock      (clock),
    .reset      (reset),
    .alloc_cnt  (alloc_cnt),
    .push_en    (push_en),
    .push_tag   (rt_old),
    .squash     (squash),
    .pop_tag    (pop_tag),
    .free_count (free_count)
  );

  // MT[0] and RRAT[0] are never written, so x0 sources always read tag 0
  always_comb begin
    for (int s = 0; s < 2; s++) dest[s] = id_valid[s] & id_has_dest[s] & (id_rd[s] != '0);
    need      = {1'b0, dest[0]} + {1'b0, dest[1]};
    shortage  = fl_cnt_t'(need) > free_count;
    rn_stall  = dp_stall | shortage;
    accept    = ~rn_stall & ~squash;
    alloc_cnt = accept ? need : 2'd0;

    prs1[0]    = mt_q[id_rs1[0]];
    prs2[0]    = mt_q[id_rs2[0]];
    prd[0]     = dest[0] ? pop_tag[0] : '0;
    old_prd[0] = dest[0] ? mt_q[id_rd[0]] : '0;

    prs1[1]    = (dest[0] && id_rs1[1] == id_rd[0]) ? prd[0] : mt_q[id_rs1[1]];
    prs2[1]    = (dest[0] && id_rs2[1] == id_rd[0]) ? prd[0] : mt_q[id_rs2[1]];
    prd[1]     = dest[1] ? (dest[0] ? pop_tag[1] : pop_tag[0]) : '0;
    old_prd[1] = '0;
    if (dest[1]) old_prd[1] = (dest[0] && id_rd[1] == id_rd[0]) ? prd[0] : mt_q[id_rd[1]];
  end

  always_comb begin
    rrat_d = rrat_q;
    for (int s = 0; s < 2; s++) begin
      push_en[s] = rt_valid[s] & (rt_rd[s] != '0);
      if (push_en[s]) rrat_d[rt_rd[s]] = rt_prd[s];
    end

    mt_d = mt_q;
    if (squash) begin
      mt_d = rrat_d;
    end else if (accept) begin
      if (dest[0]) mt_d[id_rd[0]] = prd[0];
      if (dest[1]) mt_d[id_rd[1]] = prd[1];
    end

    pkt_d = pkt_q;
    if (squash) begin
      pkt_d[0].valid = 1'b0;
      pkt_d[1].valid = 1'b0;
    end else if (!dp_stall) begin
      for (int s = 0; s < 2; s++) begin
        pkt_d[s].valid    = accept & id_valid[s];
        pkt_d[s].rs1      = id_rs1[s];
        pkt_d[s].rs2      = id_rs2[s];
        pkt_d[s].rd       = id_rd[s];
        pkt_d[s].has_dest = id_has_dest[s];
        pkt_d[s].prs1     = prs1[s];
        pkt_d[s].prs2     = prs2[s];
        pkt_d[s].prd      = prd[s];
        pkt_d[s].old_prd  = old_prd[s];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < ARCH_REGS; i++) begin
        mt_q[i]   <= prf_idx_t'(i);
        rrat_q[i] <= prf_idx_t'(i);
      end
      pkt_q <= '0;
    end else begin
      mt_q   <= mt_d;
      rrat_q <= rrat_d;
      pkt_q  <= pkt_d;
    end
  end

  assign rn_dp_packet = pkt_q;

`ifdef RN_STATS_EN
  logic [31:0] stall_cyc_q, stall_cyc_d, empty_cyc_q, empty_cyc_d;

  always_comb begin
    stall_cyc_d = stall_cyc_q;
    empty_cyc_d = empty_cyc_q;
    if (rn_stall && stall_cyc_q != '1) stall_cyc_d = stall_cyc_q + 32'd1;
    if (shortage && !dp_stall && empty_cyc_q != '1) empty_cyc_d = empty_cyc_q + 32'd1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      stall_cyc_q <= '0;
      empty_cyc_q <= '0;
    end else begin
      stall_cyc_q <= stall_cyc_d;
      empty_cyc_q <= empty_cyc_d;
    end
  end

  assign rn_stall_cycles    = stall_cyc_q;
  assign rn_fl_empty_cycles = empty_cyc_q;
`endif

endmodule

// File: tb/tb_rn_stage.sv
// tb/tb_rn_stage.sv - directed + random bench for rn_stage against a queue-based rename model
module tb_rn_stage;
  import rn_stage_pkg::*;

  logic                clock = 1'b0;
  logic                reset;
  logic [1:0]          id_valid, id_has_dest, rt_valid;
  arch_idx_t [1:0]     id_rs1, id_rs2, id_rd, rt_rd;
  prf_idx_t [1:0]      rt_prd, rt_old;
  logic                dp_stall, squash, rn_stall;
  rn_dp_packet_t [1:0] rn_dp_packet;
`ifdef RN_STATS_EN
  logic [31:0]         rn_stall_cycles, rn_fl_empty_cycles;
`endif

  int n_cmp = 0;
  int n_mis = 0;

  always #5 clock = ~clock;

  rn_stage dut (
    .clock        (clock),
    .reset        (reset),
    .id_valid     (id_valid),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_rd        (id_rd),
    .id_has_dest  (id_has_dest),
    .dp_stall     (dp_stall),
    .rt_valid     (rt_valid),
    .rt_rd        (rt_rd),
    .rt_prd       (rt_prd),
    .rt_old       (rt_old),
    .squash       (squash),
    .rn_stall     (rn_stall),
    .rn_dp_packet (rn_dp_packet)
`ifdef RN_STATS_EN
    ,
    .rn_stall_cycles    (rn_stall_cycles),
    .rn_fl_empty_cycles (rn_fl_empty_cycles)
`endif
  );

  // Reference model: map arrays, ordered free queue, allocated-not-retired queue, in-flight dests
  typedef struct { int rd; int prd; int old; } rob_t;
  int                  mt [32];
  int                  rrat [32];
  int                  fl [$];
  int                  spec [$];
  rob_t                rob [$];
  rn_dp_packet_t [1:0] exp_pkt;
  bit                  exp_stall, seen_stall;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      mt[i] = i;
      rrat[i] = i;
    end
    fl.delete();
    for (int t = 32; t < 64; t++) fl.push_back(t);
    spec.delete();
    rob.delete();
    exp_pkt = '0;
  endtask

  task automatic model_cycle();
    int need, t, o, dummy;
    bit acc;
    rn_dp_packet_t [1:0] np;
    rob_t r;
    need = 0;
    for (int s = 0; s < 2; s++) if (id_valid[s] && id_has_dest[s] && id_rd[s] != 0) need++;
    exp_stall = dp_stall || (need > fl.size());
    acc = !exp_stall && !squash;
    for (int s = 0; s < 2; s++) begin
      if (rt_valid[s] && rt_rd[s] != 0) begin
        rrat[rt_rd[s]] = int'(rt_prd[s]);
        dummy = spec.pop_front();
        fl.push_back(int'(rt_old[s]));
        r = rob.pop_front();
      end
    end
    np = '0;
    for (int s = 0; s < 2; s++) begin
      np[s].valid    = acc && id_valid[s];
      np[s].rs1      = id_rs1[s];
      np[s].rs2      = id_rs2[s];
      np[s].rd       = id_rd[s];
      np[s].has_dest = id_has_dest[s];
      np[s].prs1     = prf_idx_t'(id_rs1[s] == 0 ? 0 : mt[id_rs1[s]]);
      np[s].prs2     = prf_idx_t'(id_rs2[s] == 0 ? 0 : mt[id_rs2[s]]);
      if (acc && id_valid[s] && id_has_dest[s] && id_rd[s] != 0) begin
        t = fl.pop_front();
        o = mt[id_rd[s]];
        mt[id_rd[s]] = t;
        spec.push_back(t);
        rob.push_back('{rd: int'(id_rd[s]), prd: t, old: o});
        np[s].prd     = prf_idx_t'(t);
        np[s].old_prd = prf_idx_t'(o);
      end
    end
    if (squash) begin
      mt = rrat;
      fl = {spec, fl};
      spec.delete();
      rob.delete();
      exp_pkt[0].valid = 1'b0;
      exp_pkt[1].valid = 1'b0;
    end else if (!dp_stall) begin
      exp_pkt = np;
    end
  endtask

  task automatic cycle();
    #1;
    seen_stall = rn_stall;
    model_cycle();
    chk("rn_stall", 64'(rn_stall), 64'(exp_stall));
    @(posedge clock);
    #1;
    for (int s = 0; s < 2; s++) begin
      if (exp_pkt[s].valid) chk($sformatf("pkt%0d", s), 64'(rn_dp_packet[s]), 64'(exp_pkt[s]));
      else chk($sformatf("pkt%0d_valid", s), 64'(rn_dp_packet[s].valid), 64'd0);
    end
  endtask

  task automatic idle();
    id_valid = '0; id_has_dest = '0; id_rs1 = '0; id_rs2 = '0; id_rd = '0;
    rt_valid = '0; rt_rd = '0; rt_prd = '0; rt_old = '0;
    dp_stall = 1'b0; squash = 1'b0;
  endtask

  task automatic slot(input int s, input int rs1, input int rs2, input int rd, input bit hd);
    id_valid[s]    = 1'b1;
    id_rs1[s]      = arch_idx_t'(rs1);
    id_rs2[s]      = arch_idx_t'(rs2);
    id_rd[s]       = arch_idx_t'(rd);
    id_has_dest[s] = hd;
  endtask

  task automatic set_retire(input int n);
    rt_valid = '0;
    for (int k = 0; k < n && k < rob.size(); k++) begin
      rt_valid[k] = 1'b1;
      rt_rd[k]    = arch_idx_t'(rob[k].rd);
      rt_prd[k]   = prf_idx_t'(rob[k].prd);
      rt_old[k]   = prf_idx_t'(rob[k].old);
    end
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    model_reset();
    chk("rst_valid0", 64'(rn_dp_packet[0].valid), 64'd0);
    chk("rst_valid1", 64'(rn_dp_packet[1].valid), 64'd0);
    chk("rst_stall", 64'(rn_stall), 64'd0);
  endtask

  rn_dp_packet_t [1:0] held;

  initial begin
    idle();
    reset = 1'b1;
    @(posedge clock);
    do_reset();

    // add x1,x2,x3 ; add x4,x1,x5
    slot(0, 2, 3, 1, 1); slot(1, 1, 5, 4, 1);
    cycle();
    chk("t1_prd0", 64'(rn_dp_packet[0].prd), 64'd32);
    chk("t1_prd1", 64'(rn_dp_packet[1].prd), 64'd33);
    chk("t1_prs1_s1", 64'(rn_dp_packet[1].prs1), 64'd32);
    chk("t1_old0", 64'(rn_dp_packet[0].old_prd), 64'd1);
    chk("t1_old1", 64'(rn_dp_packet[1].old_prd), 64'd4);

    // exhaust the free list: 16 groups of two in total
    for (int g = 0; g < 15; g++) begin
      idle(); slot(0, g, g + 1, 10 + g, 1); slot(1, 3, g, 11 + g, 1);
      cycle();
    end
    idle(); slot(0, 2, 3, 20, 1); slot(1, 4, 5, 21, 1);
    cycle();
    chk("t2_stall_17th", 64'(seen_stall), 64'd1);
    set_retire(1);
    cycle();
    chk("t2_stall_retire_cycle", 64'(seen_stall), 64'd1);
    rt_valid = '0;
    cycle();
    chk("t2_stall_need2", 64'(seen_stall), 64'd1);
    idle(); slot(0, 2, 3, 9, 1); slot(1, 6, 7, 0, 0);
    cycle();
    chk("t2_go_need1", 64'(seen_stall), 64'd0);
    chk("t2_recycled_prd", 64'(rn_dp_packet[0].prd), 64'd1);

    // dp_stall holds the output and consumes nothing
    do_reset();
    slot(0, 1, 2, 3, 1); slot(1, 3, 4, 6, 1);
    cycle();
    held = exp_pkt;
    idle(); slot(0, 5, 6, 11, 1); slot(1, 7, 8, 12, 1); dp_stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk("t3_stall", 64'(seen_stall), 64'd1);
      chk("t3_hold0", 64'(rn_dp_packet[0]), 64'(held[0]));
      chk("t3_hold1", 64'(rn_dp_packet[1]), 64'(held[1]));
    end
    dp_stall = 1'b0;
    cycle();
    chk("t3_prd0", 64'(rn_dp_packet[0].prd), 64'd34);
    chk("t3_prd1", 64'(rn_dp_packet[1].prd), 64'd35);

    // both slots write x7, slot1 also reads x7
    idle(); slot(0, 1, 2, 7, 1); slot(1, 7, 7, 7, 1);
    cycle();
    chk("t4_prs1", 64'(rn_dp_packet[1].prs1), 64'd36);
    chk("t4_prs2", 64'(rn_dp_packet[1].prs2), 64'd36);
    chk("t4_old1", 64'(rn_dp_packet[1].old_prd), 64'd36);
    chk("t4_old0", 64'(rn_dp_packet[0].old_prd), 64'd7);
    idle(); slot(0, 7, 0, 0, 1);
    cycle();
    chk("t4_mt7", 64'(rn_dp_packet[0].prs1), 64'd37);
    chk("t4_x0_prd", 64'(rn_dp_packet[0].prd), 64'd0);

    // rename 6, retire 2 together with squash
    do_reset();
    slot(0, 2, 3, 1, 1); slot(1, 1, 5, 4, 1); cycle();
    idle(); slot(0, 1, 4, 5, 1); slot(1, 5, 2, 6, 1); cycle();
    idle(); slot(0, 6, 5, 8, 1); slot(1, 8, 1, 9, 1); cycle();
    idle(); slot(0, 1, 1, 10, 1);
    set_retire(2);
    chk("t5_rt_old0", 64'(rt_old[0]), 64'd1);
    squash = 1'b1;
    cycle();
    chk("t5_bubble", 64'(rn_dp_packet[0].valid), 64'd0);
    idle(); slot(0, 1, 4, 10, 1); slot(1, 5, 6, 11, 1);
    cycle();
    chk("t5_x1", 64'(rn_dp_packet[0].prs1), 64'd32);
    chk("t5_x4", 64'(rn_dp_packet[0].prs2), 64'd33);
    chk("t5_x5", 64'(rn_dp_packet[1].prs1), 64'd5);
    chk("t5_prd", 64'(rn_dp_packet[0].prd), 64'd34);
    for (int g = 0; g < 15; g++) begin
      idle(); slot(0, g, 1, 12 + g, 1); slot(1, 2, g, 13 + g, 1);
      cycle();
    end
    idle(); slot(0, 1, 2, 3, 1);
    cycle();
    chk("t5_full_after_squash", 64'(seen_stall), 64'd1);

    // random traffic with retires, x0 dests, stalls, squashes and a mid-run reset
    do_reset();
    for (int c = 0; c < 1200; c++) begin
      idle();
      for (int s = 0; s < 2; s++) begin
        if ($urandom_range(0, 3) != 0)
          slot(s, $urandom_range(0, 31), $urandom_range(0, 31),
               ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 31), $urandom_range(0, 4) != 0);
      end
      dp_stall = ($urandom_range(0, 4) == 0);
      set_retire($urandom_range(0, 2));
      squash = ($urandom_range(0, 50) == 0);
      cycle();
      if (c == 600) do_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
